// File: rtl/reg_file_ctx.sv
// reg_file_ctx: register file with a context stack.
//   Register 0 always reads as zero and register 1 always reads as all-ones.
//   Registers CTX_BASE..SIZE-1 form the context. A push saves the context
//   into the stack and a pop restores it from the stack.
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   rf_addr_r1/r2, rf_data_out1/2 two combinational read ports; an address
//                                 >= SIZE reads as zero
//   rf_addr_wr, rf_data_we,
//   rf_data_in                    write port; writes to regs 0/1 and to
//                                 addresses >= SIZE are ignored
//   rf_stack_push/pop             level-sampled save/restore requests
//   rf_err_clr                    clears the sticky ovf/unf flags
//   rf_stack_level/full/empty     stack occupancy
//   rf_stack_ovf/unf              sticky overflow/underflow flags
module reg_file_ctx #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SIZE        = 11,
    parameter int unsigned CTX_BASE    = 2,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(SIZE)-1:0]        rf_addr_r1,
    input  logic [$clog2(SIZE)-1:0]        rf_addr_r2,
    output logic [WIDTH-1:0]               rf_data_out1,
    output logic [WIDTH-1:0]               rf_data_out2,
    input  logic [$clog2(SIZE)-1:0]        rf_addr_wr,
    input  logic                           rf_data_we,
    input  logic [WIDTH-1:0]               rf_data_in,
    input  logic                           rf_stack_push,
    input  logic                           rf_stack_pop,
    input  logic                           rf_err_clr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] rf_stack_level,
    output logic                           rf_stack_full,
    output logic                           rf_stack_empty,
    output logic                           rf_stack_ovf,
    output logic                           rf_stack_unf
);

    localparam int unsigned AW   = $clog2(SIZE);
    localparam int unsigned LW   = $clog2(STACK_DEPTH + 1);
    localparam int unsigned NCTX = SIZE - CTX_BASE;

    // Only registers 2..SIZE-1 have storage; regs[k] holds register k+2.
    logic [WIDTH-1:0] regs   [SIZE-2];
    logic [WIDTH-1:0] frames [STACK_DEPTH][NCTX];
    logic [WIDTH-1:0] rd_view [SIZE];
    logic [LW-1:0]    level;
    logic             ovf, unf;
    logic             full, empty;
    logic             do_push, do_pop, ovf_evt, unf_evt;

    assign full    = (level == LW'(STACK_DEPTH));
    assign empty   = (level == '0);
    assign do_push = rf_stack_push & ~rf_stack_pop & ~full;
    assign do_pop  = rf_stack_pop & ~rf_stack_push & ~empty;
    // A simultaneous push and pop counts as both an overflow and an underflow.
    assign ovf_evt = rf_stack_push & (rf_stack_pop | full);
    assign unf_evt = rf_stack_pop & (rf_stack_push | empty);

    always_comb begin
        rd_view[0] = '0;
        rd_view[1] = '1;
        for (int unsigned i = 2; i < SIZE; i++) begin
            rd_view[i] = regs[i-2];
        end
    end

    assign rf_data_out1 = (32'(rf_addr_r1) < SIZE) ? rd_view[rf_addr_r1] : '0;
    assign rf_data_out2 = (32'(rf_addr_r2) < SIZE) ? rd_view[rf_addr_r2] : '0;

    assign rf_stack_level = level;
    assign rf_stack_full  = full;
    assign rf_stack_empty = empty;
    assign rf_stack_ovf   = ovf;
    assign rf_stack_unf   = unf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SIZE - 2; i++) begin
                regs[i] <= '0;
            end
            for (int unsigned f = 0; f < STACK_DEPTH; f++) begin
                for (int unsigned j = 0; j < NCTX; j++) begin
                    frames[f][j] <= '0;
                end
            end
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            // A pop takes priority over a write to any context register.
            for (int unsigned i = 2; i < SIZE; i++) begin
                if (rf_data_we && rf_addr_wr == AW'(i) && !(do_pop && i >= CTX_BASE)) begin
                    regs[i-2] <= rf_data_in;
                end
            end
            // The frame is selected by comparing against level, so no
            // narrowed array index is needed.
            if (do_pop) begin
                for (int unsigned f = 0; f < STACK_DEPTH; f++) begin
                    if (level == LW'(f + 1)) begin
                        for (int unsigned j = 0; j < NCTX; j++) begin
                            regs[CTX_BASE-2+j] <= frames[f][j];
                        end
                    end
                end
                level <= level - 1'b1;
            end
            // The push saves the pre-edge values, so a write in the same
            // cycle does not reach the frame.
            if (do_push) begin
                for (int unsigned f = 0; f < STACK_DEPTH; f++) begin
                    if (level == LW'(f)) begin
                        for (int unsigned j = 0; j < NCTX; j++) begin
                            frames[f][j] <= regs[CTX_BASE-2+j];
                        end
                    end
                end
                level <= level + 1'b1;
            end
            // A new error in the same cycle as a clear keeps the flag set.
            ovf <= ovf_evt | (ovf & ~rf_err_clr);
            unf <= unf_evt | (unf & ~rf_err_clr);
        end
    end

endmodule

// File: tb/tb_reg_file_ctx.sv
// Directed testbench for reg_file_ctx with the default parameters.
module tb_reg_file_ctx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] r1, r2, wa;
    logic [7:0] out1, out2, din;
    logic       we, push, pop, clr;
    logic [2:0] level;
    logic       full, empty, ovf, unf;

    int total = 0;
    int bad   = 0;

    reg_file_ctx #(.WIDTH(8), .SIZE(11), .CTX_BASE(2), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .rf_addr_r1(r1), .rf_addr_r2(r2),
        .rf_data_out1(out1), .rf_data_out2(out2),
        .rf_addr_wr(wa), .rf_data_we(we), .rf_data_in(din),
        .rf_stack_push(push), .rf_stack_pop(pop), .rf_err_clr(clr),
        .rf_stack_level(level), .rf_stack_full(full), .rf_stack_empty(empty),
        .rf_stack_ovf(ovf), .rf_stack_unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkreg(input string tag, input int a, input int exp);
        r1 = 4'(a);
        #1;
        chk(tag, out1, 8'(exp));
    endtask

    task automatic wr(input int a, input int d);
        wa = 4'(a);
        din = 8'(d);
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        r1 = '0; r2 = '0; wa = '0; din = '0;
        we = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0;
        #2;
        chk("rst_level", 8'(level), 8'd0);
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_full", 8'(full), 8'd0);
        chk("rst_ovf", 8'(ovf), 8'd0);
        chk("rst_unf", 8'(unf), 8'd0);
        chkreg("rst_reg1", 1, 8'hFF);
        chkreg("rst_reg3", 3, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // basic write/read, constant registers, out-of-range addresses
        wr(3, 8'hA5);
        r1 = 4'd3; r2 = 4'd1;
        #1;
        chk("rd_reg3", out1, 8'hA5);
        chk("rd_reg1", out2, 8'hFF);
        wr(0, 8'h55);
        chkreg("wr_reg0_ignored", 0, 0);
        wr(12, 8'h3C);
        r2 = 4'd12;
        #1;
        chk("rd_oob", out2, 8'h00);

        // single push / pop round trip
        for (int i = 2; i <= 10; i++) wr(i, 8'h10 + i - 2);
        push = 1'b1; step(); push = 1'b0;
        chk("push1_level", 8'(level), 8'd1);
        for (int i = 2; i <= 10; i++) wr(i, 0);
        chkreg("cleared_reg5", 5, 0);
        pop = 1'b1; step(); pop = 1'b0;
        chk("pop1_level", 8'(level), 8'd0);
        for (int i = 2; i <= 10; i++) chkreg($sformatf("restore_reg%0d", i), i, 8'h10 + i - 2);

        // fill the stack; frame k holds reg i = (k+1)*16 + i
        for (int k = 0; k < 4; k++) begin
            for (int i = 2; i <= 10; i++) wr(i, (k + 1) * 16 + i);
            push = 1'b1;
            if (k == 0) begin
                we = 1'b1; wa = 4'd2; din = 8'hEE;
            end
            step();
            push = 1'b0; we = 1'b0;
            chk($sformatf("fill_level%0d", k), 8'(level), 8'(k + 1));
            if (k == 0) chkreg("push_concurrent_wr", 2, 8'hEE);
        end
        chk("fill_full", 8'(full), 8'd1);
        for (int i = 2; i <= 10; i++) wr(i, 8'h50 + i);
        push = 1'b1; step(); push = 1'b0;
        chk("ovf_level", 8'(level), 8'd4);
        chk("ovf_flag", 8'(ovf), 8'd1);
        chk("ovf_unf_clear", 8'(unf), 8'd0);
        for (int m = 0; m < 4; m++) begin
            pop = 1'b1; step(); pop = 1'b0;
            chk($sformatf("drain_level%0d", m), 8'(level), 8'(3 - m));
            chkreg($sformatf("drain_reg2_%0d", m), 2, (4 - m) * 16 + 2);
            chkreg($sformatf("drain_reg10_%0d", m), 10, (4 - m) * 16 + 10);
        end
        chk("drain_empty", 8'(empty), 8'd1);
        pop = 1'b1; step(); pop = 1'b0;
        chk("unf_flag", 8'(unf), 8'd1);
        chk("unf_ovf_sticky", 8'(ovf), 8'd1);
        chk("unf_level", 8'(level), 8'd0);
        chkreg("unf_reg5", 5, 8'h15);
        pop = 1'b1; clr = 1'b1; step(); pop = 1'b0; clr = 1'b0;
        chk("clr_ovf", 8'(ovf), 8'd0);
        chk("clr_vs_new_unf", 8'(unf), 8'd1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_unf", 8'(unf), 8'd0);

        // push and pop together; pop drops concurrent context writes
        push = 1'b1; step(); push = 1'b0;
        wr(5, 8'h25);
        wr(10, 8'h2A);
        push = 1'b1; step(); push = 1'b0;
        push = 1'b1; pop = 1'b1; step(); push = 1'b0; pop = 1'b0;
        chk("both_level", 8'(level), 8'd2);
        chk("both_ovf", 8'(ovf), 8'd1);
        chk("both_unf", 8'(unf), 8'd1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("both_clr_ovf", 8'(ovf), 8'd0);
        chk("both_clr_unf", 8'(unf), 8'd0);
        pop = 1'b1; we = 1'b1; wa = 4'd5; din = 8'h77;
        step();
        pop = 1'b0; we = 1'b0;
        chk("popwr_level1", 8'(level), 8'd1);
        chkreg("popwr_reg5", 5, 8'h25);
        chkreg("popwr_reg10a", 10, 8'h2A);
        pop = 1'b1; we = 1'b1; wa = 4'd10; din = 8'h99;
        step();
        pop = 1'b0; we = 1'b0;
        chk("popwr_level0", 8'(level), 8'd0);
        chkreg("popwr_reg10", 10, 8'h1A);
        chkreg("popwr_reg5b", 5, 8'h15);

        // asynchronous reset between edges at level 3 with a push pending
        for (int k = 0; k < 3; k++) begin
            push = 1'b1; step(); push = 1'b0;
        end
        chk("pre_rst_level", 8'(level), 8'd3);
        push = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_level", 8'(level), 8'd0);
        chk("arst_empty", 8'(empty), 8'd1);
        chk("arst_full", 8'(full), 8'd0);
        for (int i = 2; i <= 10; i++) chkreg($sformatf("arst_reg%0d", i), i, 0);
        chkreg("arst_reg1", 1, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        push = 1'b0;
        step();
        pop = 1'b1; step(); pop = 1'b0;
        chk("post_rst_unf", 8'(unf), 8'd1);
        chk("post_rst_level", 8'(level), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
